dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-ported 64-word data memory between the instruction-fetch port and the load/store unit of the RV32IC core. Converts byte addresses to word addresses, performs byte/halfword load extraction with sign/zero extension, and sequences sub-word stores as a two-cycle read-modify-write. It sits between the core's fetch/LSU request interfaces and the memory's MemRead/MemWrite/addr/data_in/data_out pins.

## Interface
- No parameters. Memory depth is fixed at 64 words (6-bit word address, 8-bit byte address).
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous and active-high
- if_req  in  1  fetch read request; held until if_gnt
- if_addr  in  8  fetch byte address; bits [1:0] ignored
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  if_rdata valid (one-cycle pulse)
- if_rdata  out  32  fetched word
- ls_req  in  1  LSU request; held with attributes until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_size  in  2  00 byte, 01 half, 10 word; 11 is treated as misaligned
- ls_unsigned  in  1  zero-extend loads (LBU/LHU)
- ls_addr  in  8  LSU byte address
- ls_wdata  in  32  store data, right-aligned
- ls_gnt  out  1  LSU request accepted this cycle
- ls_rvalid  out  1  load data valid (pulse)
- ls_rdata  out  32  extended load data
- ls_wdone  out  1  store committed (pulse)
- ls_err  out  1  misaligned access rejected (pulse)
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe; memory writes on the posedge
- mem_addr  out  6  memory word address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory combinational read data

## Operation
- FSM states are IDLE and RMW_WR.
- IDLE: arbitrate among the active requests and serve the winner in the same cycle. gnt, MemRead, MemWrite, mem_addr and mem_wdata are combinational from the requests and the state.
  - Fetch or LSU load: MemRead=1, mem_addr=addr[7:2]. The extended result is registered.
  - Word store: MemWrite=1, mem_wdata=ls_wdata.
  - Byte or half store: MemRead=1. The merged word (read word with the target lane replaced) and the word address are latched, and the FSM goes to RMW_WR.
  - Misaligned access (half with addr[0]=1, word with addr[1:0]≠0, or size 11): gnt=1, no memory strobe, ls_err pulse.
- RMW_WR: MemWrite=1 with the latched address and merged data. Both gnt outputs are 0. Return to IDLE.
- Lanes are little-endian. Byte lane = addr[1:0]. Half lane = addr[1] (bits 15:0 or 31:16).
- Load extension: byte or half is sign-extended unless ls_unsigned=1. Word loads are passed through.
- Arbitration without the macro (see Configuration): fixed priority, LSU over fetch.
- While rst=1: all strobes and gnt outputs are 0. Next state is IDLE. All registered outputs are cleared.

## Timing
- Reset values: if_rvalid, ls_rvalid, ls_wdone, ls_err = 0. if_rdata and ls_rdata = 0. State = IDLE. Round-robin pointer = fetch-first.
- Read latency: rvalid and rdata appear in the cycle after gnt.
- Word store: ls_wdone in the cycle after gnt. Memory is updated at that same edge.
- Sub-word store: gnt in cycle N, MemWrite in cycle N+1, ls_wdone in cycle N+2. Neither requester is granted in cycle N+1.
- Throughput: one granted access per IDLE cycle. Back-to-back requests from the same port are allowed.
- A fetch of a word being RMW-written is not granted until after the write, so it always sees the new data.
- rst asserted in RMW_WR aborts the write: MemWrite=0, memory unchanged, no ls_wdone.
- An ungranted requester must hold req and all attributes stable. Dropping req before gnt is illegal.

## Configuration
- DMEM_ARB_RR_EN defined: two-requester round-robin. When both ports request in the same cycle, the port not granted last wins. The pointer updates only on grants made during a two-way contention. After reset, fetch wins the first tie.
- DMEM_ARB_RR_EN undefined: fixed priority, LSU always wins. Fetch can starve while ls_req is held high.

## Test plan
- Word 1 = 0x00000009. if_req with if_addr=0x04 → if_gnt same cycle, if_rvalid with if_rdata=0x00000009 next cycle.
- Word 2 = 0x80FF0019. LB at ls_addr=0x0B → ls_rdata=0xFFFFFF80. LBU → 0x00000080. LH at 0x08 → 0x00000019.
- SB of ls_wdata=0xAB at ls_addr=0x05 with word 1 = 0x00000009 → MemWrite one cycle after gnt, word 1 = 0x0000AB09, ls_wdone at N+2. if_req held throughout is not granted until N+2.
- LW at 0x06 → ls_gnt, ls_err pulse, MemRead=MemWrite=0, memory unchanged.
- Both ports request continuously for 4 cycles. With DMEM_ARB_RR_EN the grants are IF, LS, IF, LS. Without it, the grants are LS four times.
- SH in progress; rst asserted during RMW_WR → no MemWrite, target word unchanged, all pulse outputs 0, FSM in IDLE.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-ported 64-word data memory between instruction fetch and
// the load/store unit. Byte addresses become word addresses. Byte and halfword
// loads are extracted and sign- or zero-extended. Byte and halfword stores run
// as a two-cycle read-modify-write: read and merge in IDLE, then write in
// RMW_WR.
//
// Optional feature macro: DMEM_ARB_RR_EN
//   defined   -> two-way round-robin arbitration (fetch wins the first tie)
//   undefined -> fixed priority, LSU always wins
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   if_req/if_addr  fetch read request (byte address, bits [1:0] ignored)
//   if_gnt          fetch accepted this cycle (combinational)
//   if_rvalid/rdata fetched word, one cycle after if_gnt
//   ls_req/ls_we/ls_size/ls_unsigned/ls_addr/ls_wdata
//                   LSU request and its attributes
//   ls_gnt          LSU accepted this cycle (combinational)
//   ls_rvalid/rdata extended load data, one cycle after ls_gnt
//   ls_wdone        store committed (pulse)
//   ls_err          misaligned access rejected (pulse)
//   MemRead/MemWrite/mem_addr/mem_wdata/mem_rdata
//                   memory pins; mem_rdata is combinational from mem_addr
// -----------------------------------------------------------------------------
module dmem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [7:0]  if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [1:0]  ls_size,
  input  logic        ls_unsigned,
  input  logic [7:0]  ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        ls_wdone,
  output logic        ls_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [5:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {IDLE = 1'b0, RMW_WR = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic        ls_rvalid_q, ls_rvalid_d;
  logic        ls_wdone_q, ls_wdone_d;
  logic        ls_err_q, ls_err_d;
  logic [31:0] if_rdata_q;
  logic [31:0] ls_rdata_q;
  logic [5:0]  rmw_addr_q;
  logic [31:0] rmw_data_q;
  logic        rmw_start;

  // Fetch is word-granular; the low address bits carry no information.
  logic unused_if_addr_lo;
  assign unused_if_addr_lo = &{1'b0, if_addr[1:0]};

  // Misaligned: half on odd byte, word off a word boundary, or size 11.
  logic ls_misaligned;
  always_comb begin
    ls_misaligned = 1'b0;
    case (ls_size)
      2'b00:   ls_misaligned = 1'b0;
      2'b01:   ls_misaligned = ls_addr[0];
      2'b10:   ls_misaligned = |ls_addr[1:0];
      default: ls_misaligned = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic ls_win;
  logic if_win;

`ifdef DMEM_ARB_RR_EN
  // rr_ptr_q = 0: fetch wins the next tie; 1: LSU wins the next tie.
  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    ls_win   = ls_req && (!if_req || rr_ptr_q);
    rr_ptr_d = rr_ptr_q;
    // Only a contended grant in IDLE moves the pointer.
    if (!rst && (state_q == IDLE) && if_req && ls_req) begin
      rr_ptr_d = ~rr_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  assign ls_win = ls_req;
`endif

  assign if_win = if_req && !ls_win;

  // ---------------------------------------------------------------------------
  // Load lane extraction and extension
  // ---------------------------------------------------------------------------
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;

  always_comb begin
    rd_byte  = mem_rdata[{ls_addr[1:0], 3'b000} +: 8];
    rd_half  = ls_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_ext = mem_rdata;
    case (ls_size)
      2'b00:   load_ext = {{24{rd_byte[7] & ~ls_unsigned}}, rd_byte};
      2'b01:   load_ext = {{16{rd_half[15] & ~ls_unsigned}}, rd_half};
      default: load_ext = mem_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sub-word store merge: the current word with the target lane replaced
  // ---------------------------------------------------------------------------
  logic [31:0] merged;

  always_comb begin
    merged = mem_rdata;
    if (ls_size == 2'b00) begin
      merged[{ls_addr[1:0], 3'b000} +: 8] = ls_wdata[7:0];
    end else if (ls_addr[1]) begin
      merged[31:16] = ls_wdata[15:0];
    end else begin
      merged[15:0] = ls_wdata[15:0];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and memory-side outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    if_gnt      = 1'b0;
    ls_gnt      = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    mem_addr    = ls_addr[7:2];
    mem_wdata   = ls_wdata;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    ls_wdone_d  = 1'b0;
    ls_err_d    = 1'b0;
    rmw_start   = 1'b0;

    if (rst) begin
      state_d = IDLE;
    end else if (state_q == RMW_WR) begin
      // Second half of a sub-word store; nobody is granted this cycle, so a
      // fetch of the same word is served only after the write lands.
      MemWrite   = 1'b1;
      mem_addr   = rmw_addr_q;
      mem_wdata  = rmw_data_q;
      ls_wdone_d = 1'b1;
      state_d    = IDLE;
    end else if (ls_win) begin
      ls_gnt = 1'b1;
      if (ls_misaligned) begin
        ls_err_d = 1'b1;
      end else if (!ls_we) begin
        MemRead     = 1'b1;
        ls_rvalid_d = 1'b1;
      end else if (ls_size == 2'b10) begin
        MemWrite   = 1'b1;
        ls_wdone_d = 1'b1;
      end else begin
        MemRead   = 1'b1;
        rmw_start = 1'b1;
        state_d   = RMW_WR;
      end
    end else if (if_win) begin
      if_gnt      = 1'b1;
      MemRead     = 1'b1;
      mem_addr    = if_addr[7:2];
      if_rvalid_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      ls_wdone_q  <= 1'b0;
      ls_err_q    <= 1'b0;
      if_rdata_q  <= 32'h0;
      ls_rdata_q  <= 32'h0;
      rmw_addr_q  <= 6'h0;
      rmw_data_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      ls_wdone_q  <= ls_wdone_d;
      ls_err_q    <= ls_err_d;
      if (if_rvalid_d) begin
        if_rdata_q <= mem_rdata;
      end
      if (ls_rvalid_d) begin
        ls_rdata_q <= load_ext;
      end
      if (rmw_start) begin
        rmw_addr_q <= ls_addr[7:2];
        rmw_data_q <= merged;
      end
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rvalid = ls_rvalid_q;
  assign ls_rdata  = ls_rdata_q;
  assign ls_wdone  = ls_wdone_q;
  assign ls_err    = ls_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter with a behavioural 64-word memory. Expected
// responses are queued when a grant is seen; a monitor on the falling edge
// pops and compares whenever the DUT presents rvalid/wdone/err.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [1:0]  ls_size;
  logic        ls_unsigned;
  logic [7:0]  ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        ls_wdone;
  logic        ls_err;
  logic        MemRead;
  logic        MemWrite;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size),
    .ls_unsigned(ls_unsigned), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .ls_wdone(ls_wdone), .ls_err(ls_err),
    .MemRead(MemRead), .MemWrite(MemWrite), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: combinational read, write on posedge.
  logic [31:0] mem [64];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (MemWrite) mem[mem_addr] <= mem_wdata;
  end

  // kind: 0 = load data, 1 = store done, 2 = misaligned error
  typedef struct {
    int          kind;
    logic [31:0] data;
  } ls_exp_t;

  logic [31:0] if_q[$];
  ls_exp_t     ls_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  // Monitor: compare every DUT response against the head of its queue.
  logic [31:0] mon_if_exp;
  ls_exp_t     mon_ls_exp;
  int          mon_kind;
  always @(negedge clk) begin
    if (!rst) begin
      if (if_rvalid) begin
        if (if_q.size() == 0) begin
          chk("if_unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          mon_if_exp = if_q.pop_front();
          chk("if_rdata", if_rdata, mon_if_exp);
        end
      end
      if (ls_rvalid || ls_wdone || ls_err) begin
        mon_kind = ls_rvalid ? 0 : (ls_wdone ? 1 : 2);
        chk("ls_pulse_onehot", 32'(ls_rvalid) + 32'(ls_wdone) + 32'(ls_err), 32'd1);
        if (ls_q.size() == 0) begin
          chk("ls_unexpected_response", 32'(mon_kind), 32'hFFFF_FFFF);
        end else begin
          mon_ls_exp = ls_q.pop_front();
          chk("ls_kind", 32'(mon_kind), 32'(mon_ls_exp.kind));
          if (mon_ls_exp.kind == 0) chk("ls_rdata", ls_rdata, mon_ls_exp.data);
        end
      end
    end
  end

  // Issue one LSU request, wait for the grant, queue the expected response.
  // kind < 0 queues nothing. Returns the cycles waited and the strobes seen
  // in the grant cycle.
  task automatic do_ls(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [7:0] a, input logic [31:0] wd,
                       input int kind, input logic [31:0] exp,
                       output logic mr, output logic mw, output int n);
    logic got;
    got = 1'b0; n = 0; mr = 1'b0; mw = 1'b0;
    ls_req = 1'b1; ls_we = we; ls_size = sz; ls_unsigned = uns;
    ls_addr = a; ls_wdata = wd;
    while (!got && n <= 20) begin
      @(negedge clk);
      if (ls_gnt) begin
        got = 1'b1;
        mr = MemRead; mw = MemWrite;
        if (kind >= 0) ls_q.push_back(ls_exp_t'{kind, exp});
      end else begin
        n++;
      end
    end
    if (!got) chk("ls_gnt_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    ls_req = 1'b0;
  endtask

  task automatic do_if(input logic [7:0] a, input logic [31:0] exp, output int n);
    logic got;
    got = 1'b0; n = 0;
    if_req = 1'b1; if_addr = a;
    while (!got && n <= 20) begin
      @(negedge clk);
      if (if_gnt) begin
        got = 1'b1;
        if_q.push_back(exp);
      end else begin
        n++;
      end
    end
    if (!got) chk("if_gnt_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  logic mr, mw, exp_if;
  int   n;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {4{8'(i)}};
    mem[1] = 32'h0000_0009;
    mem[2] = 32'h80FF_0019;
    mem[4] = 32'h4444_4444;

    // Reset with both requests asserted: nothing may be granted or strobed.
    rst = 1'b1; if_req = 1'b1; if_addr = 8'h04;
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b10; ls_unsigned = 1'b0;
    ls_addr = 8'h08; ls_wdata = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_ls_gnt", 32'(ls_gnt), 32'd0);
    chk("rst_MemRead", 32'(MemRead), 32'd0);
    chk("rst_MemWrite", 32'(MemWrite), 32'd0);
    chk("rst_pulses", {28'd0, if_rvalid, ls_rvalid, ls_wdone, ls_err}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; if_req = 1'b0; ls_req = 1'b0;
    chk("rst_mem2_kept", mem[2], 32'h80FF_0019);

    // Fetch of word 1, granted in the request cycle.
    do_if(8'h04, 32'h0000_0009, n);
    chk("if_gnt_latency", 32'(n), 32'd0);

    // Sub-word and word loads from word 2 = 0x80FF0019.
    do_ls(1'b0, 2'b00, 1'b0, 8'h0B, 32'h0, 0, 32'hFFFF_FF80, mr, mw, n);
    chk("lb_MemRead", 32'(mr), 32'd1);
    chk("lb_MemWrite", 32'(mw), 32'd0);
    chk("lb_latency", 32'(n), 32'd0);
    do_ls(1'b0, 2'b00, 1'b1, 8'h0B, 32'h0, 0, 32'h0000_0080, mr, mw, n);
    do_ls(1'b0, 2'b01, 1'b0, 8'h08, 32'h0, 0, 32'h0000_0019, mr, mw, n);
    do_ls(1'b0, 2'b01, 1'b0, 8'h0A, 32'h0, 0, 32'hFFFF_80FF, mr, mw, n);
    do_ls(1'b0, 2'b01, 1'b1, 8'h0A, 32'h0, 0, 32'h0000_80FF, mr, mw, n);
    do_ls(1'b0, 2'b00, 1'b0, 8'h09, 32'h0, 0, 32'h0000_0000, mr, mw, n);
    do_ls(1'b0, 2'b10, 1'b0, 8'h08, 32'h0, 0, 32'h80FF_0019, mr, mw, n);

    // SB 0xAB at 0x05: read/merge in N, write in N+1, fetch waits until N+2.
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b00; ls_unsigned = 1'b0;
    ls_addr = 8'h05; ls_wdata = 32'hFFFF_FFAB;
    @(negedge clk);
    chk("sb_gnt", 32'(ls_gnt), 32'd1);
    chk("sb_MemRead", 32'(MemRead), 32'd1);
    chk("sb_MemWrite_n", 32'(MemWrite), 32'd0);
    ls_q.push_back(ls_exp_t'{1, 32'h0});
    @(posedge clk); #1;
    ls_req = 1'b0; if_req = 1'b1; if_addr = 8'h04;
    @(negedge clk);
    chk("rmw_MemWrite", 32'(MemWrite), 32'd1);
    chk("rmw_mem_addr", 32'(mem_addr), 32'd1);
    chk("rmw_mem_wdata", mem_wdata, 32'h0000_AB09);
    chk("rmw_if_gnt", 32'(if_gnt), 32'd0);
    chk("rmw_ls_gnt", 32'(ls_gnt), 32'd0);
    @(negedge clk);
    chk("sb_mem1", mem[1], 32'h0000_AB09);
    chk("sb_wdone_n2", 32'(ls_wdone), 32'd1);
    chk("sb_if_gnt_n2", 32'(if_gnt), 32'd1);
    if (if_gnt) if_q.push_back(32'h0000_AB09);
    @(posedge clk); #1;
    if_req = 1'b0;

    // Word store then half store into word 3.
    do_ls(1'b1, 2'b10, 1'b0, 8'h0C, 32'h1234_5678, 1, 32'h0, mr, mw, n);
    chk("sw_MemWrite", 32'(mw), 32'd1);
    chk("sw_MemRead", 32'(mr), 32'd0);
    chk("sw_mem3", mem[3], 32'h1234_5678);
    do_ls(1'b1, 2'b01, 1'b0, 8'h0E, 32'h0000_BEEF, 1, 32'h0, mr, mw, n);
    @(posedge clk); #1;
    chk("sh_mem3", mem[3], 32'hBEEF_5678);
    do_ls(1'b0, 2'b01, 1'b1, 8'h0E, 32'h0, 0, 32'h0000_BEEF, mr, mw, n);
    do_ls(1'b0, 2'b00, 1'b0, 8'h0F, 32'h0, 0, 32'hFFFF_FFBE, mr, mw, n);

    // Misaligned accesses: granted, no strobes, ls_err, memory unchanged.
    do_ls(1'b0, 2'b10, 1'b0, 8'h06, 32'h0, 2, 32'h0, mr, mw, n);
    chk("mis_lw_strobes", {30'd0, mr, mw}, 32'd0);
    chk("mis_lw_latency", 32'(n), 32'd0);
    do_ls(1'b1, 2'b01, 1'b0, 8'h0D, 32'h0000_FFFF, 2, 32'h0, mr, mw, n);
    chk("mis_sh_strobes", {30'd0, mr, mw}, 32'd0);
    do_ls(1'b1, 2'b11, 1'b0, 8'h04, 32'h0000_0000, 2, 32'h0, mr, mw, n);
    chk("mis_sz3_strobes", {30'd0, mr, mw}, 32'd0);
    @(posedge clk); #1;
    chk("mis_mem3", mem[3], 32'hBEEF_5678);
    chk("mis_mem1", mem[1], 32'h0000_AB09);

    // Four cycles of contention.
    if_req = 1'b1; if_addr = 8'h04;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_unsigned = 1'b0; ls_addr = 8'h08;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
`ifdef DMEM_ARB_RR_EN
      exp_if = (c % 2 == 0);
`else
      exp_if = 1'b0;
`endif
      chk("cont_if_gnt", 32'(if_gnt), 32'(exp_if));
      chk("cont_ls_gnt", 32'(ls_gnt), 32'(!exp_if));
      if (if_gnt) if_q.push_back(32'h0000_AB09);
      if (ls_gnt) ls_q.push_back(ls_exp_t'{0, 32'h80FF_0019});
    end
    @(posedge clk); #1;
    if_req = 1'b0; ls_req = 1'b0;

    // SH to word 4 aborted by reset during RMW_WR.
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b01; ls_unsigned = 1'b0;
    ls_addr = 8'h10; ls_wdata = 32'h0000_1234;
    @(negedge clk);
    chk("abort_sh_gnt", 32'(ls_gnt), 32'd1);
    @(posedge clk); #1;
    ls_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("abort_MemWrite", 32'(MemWrite), 32'd0);
    chk("abort_pulses", {28'd0, if_rvalid, ls_rvalid, ls_wdone, ls_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_mem4", mem[4], 32'h4444_4444);
    chk("abort_no_wdone", 32'(ls_wdone), 32'd0);
    @(posedge clk); #1;
    do_ls(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 0, 32'h4444_4444, mr, mw, n);
    chk("abort_idle_latency", 32'(n), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("if_queue_empty", 32'(if_q.size()), 32'd0);
    chk("ls_queue_empty", 32'(ls_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
